// File: rtl/hp_mem_responder.sv
// hp_mem_responder: AXI4 INCR-burst memory responder backed by an inferred word-addressed RAM.
// Define HP_RESP_STALL_EN to add LFSR-driven pseudo-random handshake stalls.
module hp_mem_responder #(
  parameter int HP_ADDR_WIDTH = 48,
  parameter int HP_DATA_WIDTH = 128,
  parameter int MEM_DEPTH     = 1024
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [HP_ADDR_WIDTH-1:0]   hp_awaddr,
  input  logic [7:0]                 hp_awlen,
  input  logic [2:0]                 hp_awsize,
  input  logic [1:0]                 hp_awburst,
  input  logic                       hp_awvalid,
  output logic                       hp_awready,
  input  logic [HP_DATA_WIDTH-1:0]   hp_wdata,
  input  logic [HP_DATA_WIDTH/8-1:0] hp_wstrb,
  input  logic                       hp_wlast,
  input  logic                       hp_wvalid,
  output logic                       hp_wready,
  output logic [1:0]                 hp_bresp,
  output logic                       hp_bvalid,
  input  logic                       hp_bready,
  input  logic [HP_ADDR_WIDTH-1:0]   hp_araddr,
  input  logic [7:0]                 hp_arlen,
  input  logic [2:0]                 hp_arsize,
  input  logic [1:0]                 hp_arburst,
  input  logic                       hp_arvalid,
  output logic                       hp_arready,
  output logic [HP_DATA_WIDTH-1:0]   hp_rdata,
  output logic [1:0]                 hp_rresp,
  output logic                       hp_rlast,
  output logic                       hp_rvalid,
  input  logic                       hp_rready
);

  localparam int         STRB_W     = HP_DATA_WIDTH / 8;
  localparam int         OFF_W      = $clog2(STRB_W);
  localparam int         IDX_W      = $clog2(MEM_DEPTH);
  localparam logic [2:0] LEGAL_SIZE = 3'(OFF_W);
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_SLV   = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

  logic ready_gate;
  logic launch_gate;

`ifdef HP_RESP_STALL_EN
  logic [15:0] lfsr_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) lfsr_reg <= 16'hACE1;
    else       lfsr_reg <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
  end

  assign ready_gate  = lfsr_reg[0];
  assign launch_gate = lfsr_reg[1];
`else
  assign ready_gate  = 1'b1;
  assign launch_gate = 1'b1;
`endif

  // Keeps address readies low until the first edge after reset release.
  logic init_done_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) init_done_reg <= 1'b0;
    else       init_done_reg <= 1'b1;
  end

  // ---------------- write channel ----------------
  wstate_t          wstate_reg, wstate_next;
  logic [IDX_W-1:0] widx_reg;
  logic [7:0]       wlen_reg, wcnt_reg;
  logic             wlegal_reg, werr_reg;
  logic             aw_hs, w_hs, w_final;

  assign hp_awready = init_done_reg && (wstate_reg == W_IDLE) && ready_gate;
  assign hp_wready  = (wstate_reg == W_DATA) && ready_gate;
  assign aw_hs      = hp_awvalid && hp_awready;
  assign w_hs       = hp_wvalid && hp_wready;
  assign w_final    = (wcnt_reg == wlen_reg);
  assign hp_bvalid  = (wstate_reg == W_RESP);
  assign hp_bresp   = (hp_bvalid && (!wlegal_reg || werr_reg)) ? RESP_SLV : RESP_OKAY;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) wstate_reg <= W_IDLE;
    else       wstate_reg <= wstate_next;
  end

  always_comb begin
    wstate_next = wstate_reg;
    case (wstate_reg)
      W_IDLE:  if (aw_hs) wstate_next = W_DATA;
      W_DATA:  if (w_hs && w_final) wstate_next = W_RESP;
      W_RESP:  if (hp_bready) wstate_next = W_IDLE;
      default: wstate_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      widx_reg   <= '0;
      wlen_reg   <= '0;
      wcnt_reg   <= '0;
      wlegal_reg <= 1'b0;
      werr_reg   <= 1'b0;
    end else begin
      if (aw_hs) begin
        widx_reg   <= hp_awaddr[OFF_W +: IDX_W];
        wlen_reg   <= hp_awlen;
        wcnt_reg   <= '0;
        wlegal_reg <= (hp_awburst == 2'b01) && (hp_awsize == LEGAL_SIZE);
        werr_reg   <= 1'b0;
      end
      if (w_hs) begin
        widx_reg <= widx_reg + IDX_W'(1);
        wcnt_reg <= wcnt_reg + 8'd1;
        if (hp_wlast != w_final) werr_reg <= 1'b1;
      end
    end
  end

  // ---------------- read channel ----------------
  rstate_t            rstate_reg, rstate_next;
  logic [IDX_W-1:0]   ridx_reg;
  logic [8:0]         rleft_reg;
  logic               rlegal_reg;
  logic               ar_hs, rd_issue, r_pop;
  logic               q_valid_reg, q_last_reg;
  logic               skid_valid_reg, skid_last_reg;
  logic [HP_DATA_WIDTH-1:0] skid_data_reg, ram_q_reg, beat_raw;

  assign hp_arready = init_done_reg && (rstate_reg == R_IDLE) && ready_gate;
  assign ar_hs      = hp_arvalid && hp_arready;
  // Prefetch only while the skid is empty, so a stalled head beat always has somewhere to go.
  assign rd_issue   = (rstate_reg == R_DATA) && (rleft_reg != 9'd0) && !skid_valid_reg && launch_gate;

  assign hp_rvalid  = skid_valid_reg || q_valid_reg;
  assign r_pop      = hp_rvalid && hp_rready;
  assign beat_raw   = skid_valid_reg ? skid_data_reg : ram_q_reg;
  assign hp_rdata   = (hp_rvalid && rlegal_reg) ? beat_raw : '0;
  assign hp_rlast   = skid_valid_reg ? skid_last_reg : (q_valid_reg && q_last_reg);
  assign hp_rresp   = (hp_rvalid && !rlegal_reg) ? RESP_SLV : RESP_OKAY;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rstate_reg <= R_IDLE;
    else       rstate_reg <= rstate_next;
  end

  always_comb begin
    rstate_next = rstate_reg;
    case (rstate_reg)
      R_IDLE:  if (ar_hs) rstate_next = R_DATA;
      R_DATA:  if (r_pop && hp_rlast) rstate_next = R_IDLE;
      default: rstate_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ridx_reg       <= '0;
      rleft_reg      <= '0;
      rlegal_reg     <= 1'b0;
      q_valid_reg    <= 1'b0;
      q_last_reg     <= 1'b0;
      skid_valid_reg <= 1'b0;
      skid_last_reg  <= 1'b0;
      skid_data_reg  <= '0;
    end else begin
      if (ar_hs) begin
        ridx_reg   <= hp_araddr[OFF_W +: IDX_W];
        rleft_reg  <= {1'b0, hp_arlen} + 9'd1;
        rlegal_reg <= (hp_arburst == 2'b01) && (hp_arsize == LEGAL_SIZE);
      end
      if (rd_issue) begin
        ridx_reg    <= ridx_reg + IDX_W'(1);
        rleft_reg   <= rleft_reg - 9'd1;
        q_valid_reg <= 1'b1;
        q_last_reg  <= (rleft_reg == 9'd1);
        // Head beat still in the RAM register and not taken: park it before it is overwritten.
        if (q_valid_reg && !r_pop) begin
          skid_valid_reg <= 1'b1;
          skid_data_reg  <= ram_q_reg;
          skid_last_reg  <= q_last_reg;
        end
      end else if (r_pop) begin
        if (skid_valid_reg) skid_valid_reg <= 1'b0;
        else                q_valid_reg    <= 1'b0;
      end
    end
  end

  // ---------------- storage (not reset, read-first) ----------------
  logic [HP_DATA_WIDTH-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (w_hs && wlegal_reg) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (hp_wstrb[b]) mem[widx_reg][b*8 +: 8] <= hp_wdata[b*8 +: 8];
      end
    end
    if (rd_issue) ram_q_reg <= mem[ridx_reg];
  end

endmodule
